// File: rtl/cpu_vec_pkg.sv
// Shared types for the CPU vector runner: run states and mask bit positions.
// No ports; imported by cpu_vec_store and cpu_vector_runner.
package cpu_vec_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RST  = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } stateT;

    localparam int MSK_OUTM   = 0;
    localparam int MSK_WRITEM = 1;
    localparam int MSK_ADDR   = 2;
    localparam int MSK_PC     = 3;

endpackage

// File: rtl/cpu_vec_store.sv
// Vector table: DEPTH x WIDTH register file, sync write, async read.
// Ports: CLK, we/waddr/wdata write port, raddr -> rdata read port.
module cpu_vec_store
    import cpu_vec_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int IDX_W = 5,
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [IDX_W-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);

    // No reset: table contents survive a reset of the runner.
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge CLK) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/cpu_vector_runner.sv
// Table-driven stimulus/check engine for the 16-bit Harvard CPU.
// Ports: table load (vec_*), run control (start/num_vec/stop_on_fail),
// CPU stimulus (cpu_reset/instruction/inM), CPU outputs (cpu_*),
// results (busy/done/pass/fail_count/first_fail_idx).
module cpu_vector_runner
    import cpu_vec_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 15,
    parameter int DEPTH   = 32,
    parameter int IDX_W   = $clog2(DEPTH),
    parameter int RST_CYC = 2,
    parameter int FCNT_W  = 8
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              vec_we,
    input  logic [IDX_W-1:0]  vec_waddr,
    input  logic [DATA_W-1:0] vec_instr,
    input  logic [DATA_W-1:0] vec_inM,
    input  logic [DATA_W-1:0] vec_exp_outM,
    input  logic              vec_exp_writeM,
    input  logic [ADDR_W-1:0] vec_exp_addressM,
    input  logic [ADDR_W-1:0] vec_exp_pc,
    input  logic [3:0]        vec_mask,
    input  logic              start,
    input  logic [IDX_W:0]    num_vec,
    input  logic              stop_on_fail,
    input  logic [DATA_W-1:0] cpu_outM,
    input  logic              cpu_writeM,
    input  logic [ADDR_W-1:0] cpu_addressM,
    input  logic [ADDR_W-1:0] cpu_pc,
    output logic              cpu_reset,
    output logic [DATA_W-1:0] cpu_instruction,
    output logic [DATA_W-1:0] cpu_inM,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [FCNT_W-1:0] fail_count,
    output logic [IDX_W-1:0]  first_fail_idx
);

    typedef struct packed {
        logic [DATA_W-1:0] instr;
        logic [DATA_W-1:0] inM;
        logic [DATA_W-1:0] expOutM;
        logic              expWriteM;
        logic [ADDR_W-1:0] expAddressM;
        logic [ADDR_W-1:0] expPc;
        logic [3:0]        mask;
    } vecT;

    localparam int VEC_W  = $bits(vecT);
    localparam int RCNT_W = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

    stateT             state;
    logic [IDX_W-1:0]  idx;
    logic [RCNT_W-1:0] rcnt;
    logic [IDX_W:0]    numVecQ;
    logic              stopQ;
    logic [FCNT_W-1:0] failCount;
    logic [IDX_W-1:0]  firstFail;
    logic              failSeen;

    vecT               wrVec;
    vecT               rdVec;
    logic [VEC_W-1:0]  rdBits;
    logic              canLoad;
    logic              mismatch;
    logic              lastVec;

    assign canLoad = (state == S_IDLE) || (state == S_DONE);

    assign wrVec.instr       = vec_instr;
    assign wrVec.inM         = vec_inM;
    assign wrVec.expOutM     = vec_exp_outM;
    assign wrVec.expWriteM   = vec_exp_writeM;
    assign wrVec.expAddressM = vec_exp_addressM;
    assign wrVec.expPc       = vec_exp_pc;
    assign wrVec.mask        = vec_mask;

    cpu_vec_store #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W),
        .WIDTH (VEC_W)
    ) uStore (
        .CLK   (CLK),
        .we    (vec_we && canLoad),
        .waddr (vec_waddr),
        .wdata (wrVec),
        .raddr (idx),
        .rdata (rdBits)
    );

    assign rdVec = vecT'(rdBits);

    assign mismatch =
        (rdVec.mask[MSK_OUTM]   && (cpu_outM     != rdVec.expOutM))     ||
        (rdVec.mask[MSK_WRITEM] && (cpu_writeM   != rdVec.expWriteM))   ||
        (rdVec.mask[MSK_ADDR]   && (cpu_addressM != rdVec.expAddressM)) ||
        (rdVec.mask[MSK_PC]     && (cpu_pc       != rdVec.expPc));

    assign lastVec = ({1'b0, idx} + (IDX_W+1)'(1)) == numVecQ;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            idx       <= '0;
            rcnt      <= '0;
            numVecQ   <= '0;
            stopQ     <= 1'b0;
            failCount <= '0;
            firstFail <= '0;
            failSeen  <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state     <= S_RST;
                        numVecQ   <= num_vec;
                        stopQ     <= stop_on_fail;
                        failCount <= '0;
                        firstFail <= '0;
                        failSeen  <= 1'b0;
                        idx       <= '0;
                        rcnt      <= '0;
                    end
                end
                S_RST: begin
                    if (rcnt == RCNT_W'(RST_CYC - 1)) begin
                        state <= (numVecQ == '0) ? S_DONE : S_RUN;
                    end else begin
                        rcnt <= rcnt + RCNT_W'(1);
                    end
                end
                S_RUN: begin
                    if (mismatch) begin
                        if (failCount != '1) begin
                            failCount <= failCount + FCNT_W'(1);
                        end
                        // failSeen distinguishes "first fail at 0" from none.
                        if (!failSeen) begin
                            firstFail <= idx;
                            failSeen  <= 1'b1;
                        end
                    end
                    if (lastVec || (mismatch && stopQ)) begin
                        state <= S_DONE;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign cpu_reset       = (state != S_RUN);
    assign cpu_instruction = (state == S_RUN) ? rdVec.instr : '0;
    assign cpu_inM         = (state == S_RUN) ? rdVec.inM : '0;
    assign busy            = (state == S_RST) || (state == S_RUN);
    assign done            = (state == S_DONE);
    assign pass            = done && (failCount == '0);
    assign fail_count      = failCount;
    assign first_fail_idx  = firstFail;

endmodule
